// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the multi-port register file.
//   WIDTH_DEF  - default register width (bits)
//   DEPTH_DEF  - default number of registers
//   NREAD_DEF  - default number of read ports
//   reg_word_t - one register word at the default width
package regfile_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int DEPTH_DEF = 32;
  localparam int NREAD_DEF = 2;

  typedef logic [WIDTH_DEF-1:0] reg_word_t;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port of the register file.
//   clk_i, reset_n_i      - clock, asynchronous active-low reset
//   rd_en_i, rd_addr_i    - read request and index
//   wr_en_i, wr_addr_i,
//   wr_data_i             - write port, observed for same-cycle bypass
//   mem_i                 - flattened storage array from the top
//   rd_data_o, rd_valid_o - read value and valid flag (registered when
//                           SYNC_READ=1, combinational otherwise)
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ZERO_REG  = DEPTH - 1,
  parameter int SYNC_READ = 1,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        rd_en_i,
  input  logic [AW-1:0]               rd_addr_i,
  input  logic                        wr_en_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic                        rd_valid_o
);

  // One extra bit so the range compare works when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_REG);

  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] val_d;
  logic             addr_ok;

  // DEPTH:1 mux written as a compare loop so non-power-of-two depths never
  // index past the array.
  always_comb begin
    word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == AW'(i)) word = mem_i[i];
    end
  end

  assign addr_ok = ({1'b0, rd_addr_i} < DEPTH_W) && (rd_addr_i != ZERO_A);

  // Zero/out-of-range override wins, so the bypass can never leak into XZR.
  always_comb begin
    val_d = '0;
    if (addr_ok) begin
      val_d = (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : word;
    end
  end

  if (SYNC_READ != 0) begin : g_sync
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_en_i;
        // Data holds when the port is idle.
        if (rd_en_i) rd_data_q <= val_d;
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ reset_n_i;
    assign rd_data_o      = val_d;
    assign rd_valid_o     = rd_en_i;
  end

endmodule

// File: rtl/regfile_np.sv
// regfile_np: DEPTH x WIDTH register file, one write port, NREAD read ports.
//   clk, reset_n       - clock, asynchronous active-low reset
//   wr_en, wr_addr,
//   wr_data            - write port (ignored for ZERO_REG / out of range)
//   rd_en, rd_addr     - per-port read request and index
//   rd_data, rd_valid  - per-port read value and valid flag
module regfile_np
  import regfile_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int NREAD     = NREAD_DEF,
  parameter  int ZERO_REG  = DEPTH - 1,
  parameter  int SYNC_READ = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [NREAD-1:0]            rd_en,
  input  logic [NREAD-1:0][AW-1:0]    rd_addr,
  output logic [NREAD-1:0][WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]            rd_valid
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_d;

  // Out-of-range addresses match no entry; ZERO_REG is skipped so it
  // stays at its reset value of zero.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (i != ZERO_REG) && (wr_addr == AW'(i))) mem_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_q <= '0;
    else          mem_q <= mem_d;
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .SYNC_READ(SYNC_READ),
      .AW       (AW)
    ) u_port (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .rd_en_i   (rd_en[p]),
      .rd_addr_i (rd_addr[p]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .mem_i     (mem_q),
      .rd_data_o (rd_data[p]),
      .rd_valid_o(rd_valid[p])
    );
  end

endmodule
